// File: rtl/store_drain_unit.sv
// ---------------------------------------------------------------------------
// store_drain_unit
//
// Write-side back end of the store buffer. Counts stores retired by the ROB,
// pops them one at a time from the store buffer head and issues each one to
// the data cache over an SRAM-like req/addr_ok/data_ok write interface.
// drain_empty tells the pipeline when every committed store has completed.
//
// Optional feature macro: STORE_DRAIN_PERF_EN
//   When defined, adds perf_store_cnt / perf_stall_cnt performance counters.
//
// Ports:
//   clk, reset           core clock, synchronous active-high reset
//   rob_store_commit     one store retired this cycle
//   commit_store_valid   one-cycle pop strobe to the store buffer head
//   commit_store_wstrb   head entry byte strobe (valid with the pop)
//   commit_store_addr    head entry address
//   commit_store_data    head entry data
//   data_req/wr/size/addr/wstrb/wdata   dcache write request
//   data_addr_ok         request accepted
//   data_data_ok         write complete
//   drain_empty          no pending and no in-flight store
//   pending_cnt          committed stores not yet popped
//   overflow_err         sticky: commit seen while the counter was full
//   perf_store_cnt       (optional) completed writes, wrapping
//   perf_stall_cnt       (optional) cycles stalled on the cache, wrapping
// ---------------------------------------------------------------------------
module store_drain_unit #(
    parameter int STORE_GROUP = 8,
    parameter int CNT_W       = $clog2(STORE_GROUP) + 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             rob_store_commit,
    output logic             commit_store_valid,
    input  logic [3:0]       commit_store_wstrb,
    input  logic [31:0]      commit_store_addr,
    input  logic [31:0]      commit_store_data,
    output logic             data_req,
    output logic             data_wr,
    output logic [1:0]       data_size,
    output logic [31:0]      data_addr,
    output logic [3:0]       data_wstrb,
    output logic [31:0]      data_wdata,
    input  logic             data_addr_ok,
    input  logic             data_data_ok,
    output logic             drain_empty,
    output logic [CNT_W-1:0] pending_cnt,
`ifdef STORE_DRAIN_PERF_EN
    output logic [31:0]      perf_store_cnt,
    output logic [31:0]      perf_stall_cnt,
`endif
    output logic             overflow_err
);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] REQ  = 2'd1;
    localparam logic [1:0] WAIT = 2'd2;

    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(STORE_GROUP);

    logic [1:0]  state;
    logic [1:0]  size_q;
    logic [31:0] addr_q;
    logic [3:0]  wstrb_q;
    logic [31:0] wdata_q;

    logic [1:0]  pop_size;
    logic [1:0]  pop_offset;

    // Pops only happen from IDLE, so nothing is popped while a store is in
    // flight; the strobe depends only on registered state.
    assign commit_store_valid = (state == IDLE) && (pending_cnt != '0);

    assign data_req    = (state == REQ);
    assign data_wr     = 1'b1;
    assign data_size   = size_q;
    assign data_addr   = addr_q;
    assign data_wstrb  = wstrb_q;
    assign data_wdata  = wdata_q;
    assign drain_empty = (pending_cnt == '0) && (state == IDLE);

    // Strobe decode: single bytes and aligned halves get narrow sizes with the
    // low address bits pointing at the lane; everything else (full word and the
    // SWL/SWR partial forms) is issued as a word with the strobe passed through.
    always_comb begin
        pop_size   = 2'd2;
        pop_offset = 2'd0;
        case (commit_store_wstrb)
            4'b0001: begin pop_size = 2'd0; pop_offset = 2'd0; end
            4'b0010: begin pop_size = 2'd0; pop_offset = 2'd1; end
            4'b0100: begin pop_size = 2'd0; pop_offset = 2'd2; end
            4'b1000: begin pop_size = 2'd0; pop_offset = 2'd3; end
            4'b0011: begin pop_size = 2'd1; pop_offset = 2'd0; end
            4'b1100: begin pop_size = 2'd1; pop_offset = 2'd2; end
            default: begin pop_size = 2'd2; pop_offset = 2'd0; end
        endcase
    end

    // Pending counter: a commit and a pop in the same cycle cancel out. A
    // commit with no pop while full saturates and latches the sticky error.
    always_ff @(posedge clk) begin
        if (reset) begin
            pending_cnt  <= '0;
            overflow_err <= 1'b0;
        end else if (rob_store_commit && !commit_store_valid) begin
            if (pending_cnt == CNT_FULL) begin
                overflow_err <= 1'b1;
            end else begin
                pending_cnt <= pending_cnt + 1'b1;
            end
        end else if (!rob_store_commit && commit_store_valid) begin
            pending_cnt <= pending_cnt - 1'b1;
        end
    end

    // Issue FSM. A zero-strobe entry is popped but never sent to the cache.
    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= IDLE;
            size_q  <= 2'd0;
            addr_q  <= 32'd0;
            wstrb_q <= 4'd0;
            wdata_q <= 32'd0;
        end else begin
            case (state)
                IDLE: begin
                    if (commit_store_valid) begin
                        size_q  <= pop_size;
                        addr_q  <= {commit_store_addr[31:2], pop_offset};
                        wstrb_q <= commit_store_wstrb;
                        wdata_q <= commit_store_data;
                        if (commit_store_wstrb != 4'd0) begin
                            state <= REQ;
                        end
                    end
                end
                REQ: begin
                    if (data_addr_ok && data_data_ok) begin
                        state <= IDLE;
                    end else if (data_addr_ok) begin
                        state <= WAIT;
                    end
                end
                WAIT: begin
                    if (data_data_ok) begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

`ifdef STORE_DRAIN_PERF_EN
    // Free-running wrapping counters for completed writes and cache stalls.
    always_ff @(posedge clk) begin
        if (reset) begin
            perf_store_cnt <= 32'd0;
            perf_stall_cnt <= 32'd0;
        end else begin
            if (data_data_ok) begin
                perf_store_cnt <= perf_store_cnt + 32'd1;
            end
            if ((state == REQ && !data_addr_ok) || (state == WAIT && !data_data_ok)) begin
                perf_stall_cnt <= perf_stall_cnt + 32'd1;
            end
        end
    end
`endif

endmodule
